// File: rtl/gpi_irq_periph.sv
// rtl/gpi_irq_periph.sv - APB general-purpose input block with per-pin edge interrupts
// Inputs are synchronized, masked by CR, and edge-detected into sticky W1C flags.
module gpi_irq_periph #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [4:0]       PADDR,
  input  logic             PWRITE,
  input  logic             PENABLE,
  input  logic [31:0]      PWDATA,
  input  logic             PSEL,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  input  logic [WIDTH-1:0] gpi,
  output logic             irq
);

  localparam logic [2:0] A_CR   = 3'd0;
  localparam logic [2:0] A_IDR  = 3'd1;
  localparam logic [2:0] A_RIER = 3'd2;
  localparam logic [2:0] A_FIER = 3'd3;
  localparam logic [2:0] A_ISR  = 3'd4;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] cr_q, cr_d;
  logic [WIDTH-1:0] rier_q, rier_d;
  logic [WIDTH-1:0] fier_q, fier_d;
  logic [WIDTH-1:0] isr_q, isr_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] masked, rise, fall, w1c, wdata, rdata;
  logic             access, wr_en, rd_en;
  logic [2:0]       word;
  logic             unused_bits;

  assign access      = PSEL & PENABLE;
  assign PREADY      = access;
  assign wr_en       = access & PWRITE;
  assign rd_en       = access & ~PWRITE;
  assign word        = PADDR[4:2];
  assign wdata       = PWDATA[WIDTH-1:0];
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  // Disabling a pin drives its masked value low, so CR changes create edges too.
  assign masked = sync_q[SYNC_STAGES-1] & cr_q;
  assign rise   = masked & ~prev_q;
  assign fall   = prev_q & ~masked;

  always_comb begin
    sync_d[0] = gpi;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    cr_d   = cr_q;
    rier_d = rier_q;
    fier_d = fier_q;
    w1c    = '0;
    if (wr_en) begin
      case (word)
        A_CR:    cr_d   = wdata;
        A_RIER:  rier_d = wdata;
        A_FIER:  fier_d = wdata;
        A_ISR:   w1c    = wdata;
        default: ;
      endcase
    end
    // New events are OR-ed in after the clear so a coincident set survives.
    isr_d  = (isr_q & ~w1c) | (rise & rier_q) | (fall & fier_q);
    prev_d = masked;
  end

  always_comb begin
    rdata = '0;
    case (word)
      A_CR:    rdata = cr_q;
      A_IDR:   rdata = masked;
      A_RIER:  rdata = rier_q;
      A_FIER:  rdata = fier_q;
      A_ISR:   rdata = isr_q;
      default: rdata = '0;
    endcase
    PRDATA = rd_en ? 32'(rdata) : 32'h0;
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      cr_q   <= '0;
      rier_q <= '0;
      fier_q <= '0;
      isr_q  <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      cr_q   <= cr_d;
      rier_q <= rier_d;
      fier_q <= fier_d;
      isr_q  <= isr_d;
      prev_q <= prev_d;
    end
  end

  assign irq = |isr_q;

endmodule

// File: tb/tb_gpi_irq_periph.sv
// tb/tb_gpi_irq_periph.sv - self-checking bench for gpi_irq_periph
module tb_gpi_irq_periph;

  localparam int SYNC = 2;

  logic        pclk = 1'b0;
  logic        presetn = 1'b1;
  logic [4:0]  paddr = '0;
  logic        pwrite = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] pwdata = '0;
  logic        psel = 1'b0;
  logic        sel4 = 1'b0;
  logic [7:0]  gpi8 = '0;
  logic [3:0]  gpi4 = '0;
  logic [31:0] prdata8, prdata4;
  logic        pready8, pready4, irq8, irq4;
  logic        psel8, psel4_s, wr8;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_irq = 1'b0;

  assign psel8   = psel & ~sel4;
  assign psel4_s = psel & sel4;
  assign wr8     = psel8 & penable & pwrite;

  always #5 pclk = ~pclk;

  gpi_irq_periph #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut (
    .PCLK(pclk), .PRESET(presetn), .PADDR(paddr), .PWRITE(pwrite), .PENABLE(penable),
    .PWDATA(pwdata), .PSEL(psel8), .PRDATA(prdata8), .PREADY(pready8), .gpi(gpi8), .irq(irq8)
  );

  gpi_irq_periph #(.WIDTH(4), .SYNC_STAGES(SYNC)) dut4 (
    .PCLK(pclk), .PRESET(presetn), .PADDR(paddr), .PWRITE(pwrite), .PENABLE(penable),
    .PWDATA(pwdata), .PSEL(psel4_s), .PRDATA(prdata4), .PREADY(pready4), .gpi(gpi4), .irq(irq4)
  );

  // Reference: a log of gpi samples indexed by edge count since reset; the
  // synchronized view is simply the sample taken SYNC edges earlier.
  logic [7:0]  glog [256];
  int unsigned ne;
  logic [7:0]  mcr, mrier, mfier, misr, mprev;
  logic [7:0]  m_sync, m_m, m_set, m_clr;

  assign m_sync = (ne >= SYNC) ? glog[8'(ne - SYNC)] : 8'h00;
  assign m_m    = m_sync & mcr;
  assign m_set  = (m_m & ~mprev & mrier) | (~m_m & mprev & mfier);
  assign m_clr  = (wr8 && paddr[4:2] == 3'd4) ? pwdata[7:0] : 8'h00;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ne <= 0; mcr <= '0; mrier <= '0; mfier <= '0; misr <= '0; mprev <= '0;
    end else begin
      glog[ne[7:0]] <= gpi8;
      ne    <= ne + 1;
      misr  <= (misr & ~m_clr) | m_set;
      mprev <= m_m;
      if (wr8) begin
        case (paddr[4:2])
          3'd0: mcr   <= pwdata[7:0];
          3'd2: mrier <= pwdata[7:0];
          3'd3: mfier <= pwdata[7:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    case (a[4:2])
      3'd0: return {24'h0, mcr};
      3'd1: return {24'h0, m_m};
      3'd2: return {24'h0, mrier};
      3'd3: return {24'h0, mfier};
      3'd4: return {24'h0, misr};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (chk_irq) check("irq_vs_model", {31'h0, irq8}, {31'h0, (misr != 8'h00)});
  end

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); bus_idle();
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1 check({name, "_setup_zero"}, sel4 ? prdata4 : prdata8, 32'h0);
    @(negedge pclk); penable = 1'b1;
    #1 check(name, sel4 ? prdata4 : prdata8, exp);
    if (!sel4) check("pready", {31'h0, pready8}, 32'h1);
    @(negedge pclk); bus_idle();
  endtask

  task automatic do_reset();
    @(negedge pclk); bus_idle(); presetn = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{5'h00, 32'h000000FF, 5'h00, 32'h000000FF};
    tbl[1] = '{5'h08, 32'hDEADBE5A, 5'h08, 32'h0000005A};
    tbl[2] = '{5'h0C, 32'h12345678, 5'h0C, 32'h00000078};
    tbl[3] = '{5'h04, 32'h000000FF, 5'h04, 32'h00000000};
    tbl[4] = '{5'h18, 32'hFFFFFFFF, 5'h18, 32'h00000000};
    tbl[5] = '{5'h1C, 32'h00000000, 5'h00, 32'h000000FF};
    tbl[6] = '{5'h10, 32'h000000FF, 5'h10, 32'h00000000};
    tbl[7] = '{5'h00, 32'h00000000, 5'h00, 32'h00000000};
    tbl[8] = '{5'h14, 32'h000000AA, 5'h14, 32'h00000000};

    #1 presetn = 1'b0;
    repeat (2) @(negedge pclk);
    check("irq_in_reset", {31'h0, irq8}, 32'h0);
    presetn = 1'b1;
    chk_irq = 1'b1;
    for (int i = 0; i < 5; i++) rd("reset_reg", 5'(i * 4), 32'h0);

    for (int i = 0; i < 9; i++) begin
      wr(tbl[i].waddr, tbl[i].wdata);
      rd($sformatf("tbl%0d", i), tbl[i].raddr, tbl[i].exp);
    end
    wr(5'h08, 0); wr(5'h0C, 0);

    // IDR latency and masking
    wr(5'h00, 32'hFF);
    @(negedge pclk); psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 5'h04; gpi8 = 8'hA5;
    #1 check("idr_before", prdata8, 32'h00);
    @(negedge pclk); #1 check("idr_edge_k", prdata8, 32'h00);
    @(negedge pclk); #1 check("idr_edge_k1", prdata8, 32'hA5);
    bus_idle();
    wr(5'h00, 32'h0F);
    rd("idr_masked", 5'h04, 32'h05);

    // Rising-edge flag latency and W1C clear
    gpi8 = 8'h00;
    do_reset();
    wr(5'h00, 32'h01); wr(5'h08, 32'h01);
    @(negedge pclk); psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 5'h10; gpi8 = 8'h01;
    @(negedge pclk); #1 check("isr_k", prdata8, 32'h0);
    @(negedge pclk); #1 check("isr_k1", prdata8, 32'h0);
    check("irq_k1", {31'h0, irq8}, 32'h0);
    @(negedge pclk); #1 check("isr_k2", prdata8, 32'h1);
    check("irq_k2", {31'h0, irq8}, 32'h1);
    bus_idle();
    wr(5'h10, 32'h01);
    check("irq_cleared", {31'h0, irq8}, 32'h0);
    rd("isr_cleared", 5'h10, 32'h0);

    // Falling edge set coincides with W1C: set wins
    do_reset();
    @(negedge pclk); gpi8 = 8'h80;
    wr(5'h0C, 32'h80); wr(5'h00, 32'h80);
    repeat (3) @(negedge pclk);
    rd("isr_pre_fall", 5'h10, 32'h0);
    @(negedge pclk); gpi8 = 8'h00;
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h10; pwdata = 32'h80;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); bus_idle();
    rd("isr_set_wins", 5'h10, 32'h80);
    check("irq_set_wins", {31'h0, irq8}, 32'h1);
    wr(5'h10, 32'h80);
    rd("isr_after_w1c", 5'h10, 32'h0);

    // Asynchronous reset with pending flags, release with inputs high
    do_reset();
    wr(5'h00, 32'hFF); wr(5'h08, 32'hFF);
    @(negedge pclk); gpi8 = 8'h3C;
    repeat (4) @(negedge pclk);
    rd("isr_3c", 5'h10, 32'h3C);
    @(posedge pclk); #2 presetn = 1'b0;
    #1 check("irq_async_reset", {31'h0, irq8}, 32'h0);
    @(negedge pclk); gpi8 = 8'hFF;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    repeat (4) @(negedge pclk);
    for (int i = 0; i < 5; i++) rd("post_reset_reg", 5'(i * 4), 32'h0);

    // Reset during an access phase aborts the write
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'hFF;
    @(negedge pclk); penable = 1'b1; presetn = 1'b0;
    @(negedge pclk); bus_idle(); presetn = 1'b1;
    rd("cr_aborted", 5'h00, 32'h0);

    // Unmapped and read-only writes, narrow instance
    rd("unmapped_18", 5'h18, 32'h0);
    @(negedge pclk); gpi8 = 8'h5A;
    wr(5'h00, 32'hFF);
    repeat (2) @(negedge pclk);
    rd("idr_5a", 5'h04, 32'h5A);
    wr(5'h04, 32'hFF);
    rd("idr_ro", 5'h04, 32'h5A);
    sel4 = 1'b1;
    wr(5'h00, 32'hFFFFFFFF);
    rd("w4_cr", 5'h00, 32'h0000000F);
    sel4 = 1'b0;

    // Toggling CR with the pin held high yields exactly one rise per enable
    do_reset();
    @(negedge pclk); gpi8 = 8'h02;
    wr(5'h08, 32'h02); wr(5'h00, 32'h02);
    repeat (3) @(negedge pclk);
    rd("cr_enable_rise", 5'h10, 32'h02);
    wr(5'h10, 32'h02);
    rd("cr_rise_cleared", 5'h10, 32'h0);
    wr(5'h00, 32'h00);
    repeat (3) @(negedge pclk);
    rd("cr_disable_no_flag", 5'h10, 32'h0);
    wr(5'h00, 32'h02);
    repeat (3) @(negedge pclk);
    rd("cr_reenable_rise", 5'h10, 32'h02);

    // Randomized traffic against the reference model
    do_reset();
    for (int it = 0; it < 600; it++) begin
      logic [4:0] a;
      @(negedge pclk);
      if ($urandom_range(0, 3) == 0) gpi8 = 8'($urandom);
      a = 5'($urandom);
      case ($urandom_range(0, 4))
        0: ;
        1: wr(a, $urandom);
        2: wr(5'($urandom_range(0, 3) * 4) | 5'($urandom_range(0, 3)), $urandom);
        3: wr(5'h10, $urandom);
        default: begin
          @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
          @(negedge pclk); penable = 1'b1;
          #1 check($sformatf("rand_rd_%02h", a), prdata8, exp_rd(a));
          @(negedge pclk); bus_idle();
        end
      endcase
    end

    chk_irq = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
